fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and load-use hazard unit for the pipelined MIPS core; generalises the fixed two-stage (EX/MEM, MEM/WB) forwarding logic.
- Keeps a registered tracker of in-flight register writes across DEPTH post-EX stages, each tagged with the stage at which its result becomes forwardable.
- For NUM_SRC operand addresses in the EX stage, produces per-operand bypass selects, plus a stall request when the youngest producer's result is not yet available.

Parameters:
- NUM_SRC, 2, number of source operands checked (rs, rt, ...).
- DEPTH, 3, number of tracked post-EX stages (stage 1 = EX/MEM).
- ADDR_W, 5, register address width.
- LAT_W, 2, width of the latency tag (forwardable-from stage index).
- SEL_W, $clog2(DEPTH+1), width of each select field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- hold_i  in  1  global pipeline freeze (e.g. memory wait); tracker holds its state.
- flush_i  in  1  the instruction currently in EX is squashed; inserts a bubble.
- iss_valid_i  in  1  EX-stage instruction valid.
- iss_wen_i  in  1  EX-stage instruction writes a register.
- iss_rd_i  in  ADDR_W  EX-stage destination register.
- iss_lat_i  in  LAT_W  first stage at which its result is forwardable (1 = ALU, 2 = load).
- src_addr_i  in  NUM_SRC*ADDR_W  EX-stage source addresses; operand j is at bits [j*ADDR_W +: ADDR_W].
- src_sel_o  out  NUM_SRC*SEL_W  per-operand select: 0 = register file, k = forward from stage k.
- stall_o  out  1  load-use hazard; EX instruction must be held and a bubble issued.

Behaviour:
- Tracker: DEPTH entries {valid, rd, lat}, all registered. Entry k describes the instruction currently in stage k.
- Reset (asynchronous, rst_i=1):
  - All entries invalid.
  - src_sel_o = 0 and stall_o = 0, because both are derived from the empty tracker.
- Advance on each clock edge when hold_i=0:
  - Entry k+1 <= entry k for k = 1..DEPTH-1; the entry leaving stage DEPTH is discarded.
  - Entry 1 <= {iss_valid_i & iss_wen_i & (iss_rd_i != 0), iss_rd_i, iss_lat_i}.
  - Entry 1 becomes a bubble (valid=0) when flush_i=1 or stall_o=1.
- hold_i=1: tracker frozen entirely; this overrides flush_i and stall_o.
- Match rule, per operand j:
  - Stage k matches when valid_k, rd_k == src_j, and src_j != 0.
  - Only the youngest match (smallest k) counts; older matches are shadowed.
- Select rule:
  - If the youngest match has lat_k <= k, then src_sel_o[j] = k.
  - If there is no match, or src_j == 0, then src_sel_o[j] = 0.
- Stall rule:
  - If the youngest match has lat_k > k, that operand is "not ready" and src_sel_o[j] = 0.
  - stall_o = OR of the not-ready flags over all operands, qualified by iss_valid_i.
- Timing: src_sel_o and stall_o are combinational from the registered tracker and the current src_addr_i / iss_valid_i. Zero-cycle latency, no input-to-register loop.
- Stall duration: a load (lat=2) followed immediately by a dependent instruction stalls exactly 1 cycle. On the next cycle the load sits in stage 2 and src_sel_o = 2.
- Values of iss_lat_i outside 1..DEPTH:
  - iss_lat_i = 0 is treated as 1.
  - iss_lat_i > DEPTH means the result is never forwardable. A dependent operand stalls until the entry retires, then reads the register file.
- Simultaneous flush_i and stall_o: bubble inserted; flush_i wins for the issuing slot.
- Reset mid-stall: stall_o drops asynchronously with the tracker clear.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- When defined:
  - Adds output fwd_cnt_o (32 bits): number of cycles with at least one non-zero select and iss_valid_i=1.
  - Adds output stall_cnt_o (32 bits): number of cycles with stall_o=1 and hold_i=0.
  - Both counters saturate at all-ones, reset to 0 on rst_i, and do not count while hold_i=1.
- When not defined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package fwd_pkg holds:
  - SEL_RF = 0.
  - LAT_ALU = 1, LAT_LOAD = 2.
  - typedef fwd_entry_t {valid, rd, lat}.
- Sub-module fwd_match: one instance per operand (generate loop). Purely combinational priority search over the tracker; outputs sel and not_ready.

Test Plan:
- Reset: assert rst_i mid-run with entries valid -> src_sel_o = 0 and stall_o = 0 immediately, before any clock edge.
- ALU back-to-back: issue rd=3, lat=1; next cycle src0=3 -> src_sel_o[0] = 1. One cycle later (intervening instruction with no write) -> sel = 2. After DEPTH+1 cycles -> sel = 0.
- Load-use: issue rd=8, lat=2; next cycle src1=8 -> stall_o = 1 and stage 1 receives a bubble. Following cycle -> stall_o = 0 and src_sel_o[1] = 2.
- Youngest wins: stage 2 holds rd=5 (lat=1), then issue rd=5 (lat=1); next cycle src0=5 and src1=5 -> both selects = 1.
- Register zero: issue rd=0, wen=1; next cycle src0=0 -> sel = 0 and stall_o = 0. Entry is stored as invalid.
- Hold and flush: hold_i=1 for 3 cycles -> tracker unchanged and selects stable. flush_i=1 with iss rd=4 -> later src0=4 -> sel = 0.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants and tracker entry type for the forwarding scoreboard.
package fwd_pkg;

    localparam int unsigned FWD_ADDR_W = 5;
    localparam int unsigned FWD_LAT_W  = 2;

    localparam int unsigned SEL_RF   = 0;
    localparam int unsigned LAT_ALU  = 1;
    localparam int unsigned LAT_LOAD = 2;

    typedef struct packed {
        logic                  valid;
        logic [FWD_ADDR_W-1:0] rd;
        logic [FWD_LAT_W-1:0]  lat;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// Issue/operand bundle of the forwarding scoreboard.
// FWD_SCOREBOARD_STATS_EN adds the forward/stall event counters.
interface fwd_scoreboard_if #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LAT_W   = 2,
    parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
);
    logic                      hold_i;
    logic                      flush_i;
    logic                      iss_valid_i;
    logic                      iss_wen_i;
    logic [ADDR_W-1:0]         iss_rd_i;
    logic [LAT_W-1:0]          iss_lat_i;
    logic [NUM_SRC*ADDR_W-1:0] src_addr_i;
    logic [NUM_SRC*SEL_W-1:0]  src_sel_o;
    logic                      stall_o;
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0]               fwd_cnt_o;
    logic [31:0]               stall_cnt_o;

    modport master (
        output hold_i, flush_i, iss_valid_i, iss_wen_i, iss_rd_i, iss_lat_i, src_addr_i,
        input  src_sel_o, stall_o, fwd_cnt_o, stall_cnt_o
    );
    modport slave (
        input  hold_i, flush_i, iss_valid_i, iss_wen_i, iss_rd_i, iss_lat_i, src_addr_i,
        output src_sel_o, stall_o, fwd_cnt_o, stall_cnt_o
    );
`else
    modport master (
        output hold_i, flush_i, iss_valid_i, iss_wen_i, iss_rd_i, iss_lat_i, src_addr_i,
        input  src_sel_o, stall_o
    );
    modport slave (
        input  hold_i, flush_i, iss_valid_i, iss_wen_i, iss_rd_i, iss_lat_i, src_addr_i,
        output src_sel_o, stall_o
    );
`endif
endinterface

// File: rtl/fwd_scoreboard_match.sv
// Priority search of the tracker for one source operand: youngest matching
// producer decides between a bypass select and a not-ready flag.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned ADDR_W = FWD_ADDR_W,
    parameter int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
    input  fwd_entry_t        trk [DEPTH],
    input  logic [ADDR_W-1:0] src,
    output logic [SEL_W-1:0]  sel,
    output logic              not_ready
);
    logic                 found;
    logic [FWD_LAT_W-1:0] eff_lat;

    always_comb begin
        sel       = '0;
        not_ready = 1'b0;
        found     = 1'b0;
        eff_lat   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!found && trk[i].valid && (trk[i].rd == src) && (src != '0)) begin
                found = 1'b1;
                // a zero latency tag behaves as an ALU result
                eff_lat = (trk[i].lat == '0) ? FWD_LAT_W'(LAT_ALU) : trk[i].lat;
                if (32'(eff_lat) <= i + 1)
                    sel = SEL_W'(i + 1);
                else
                    not_ready = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding / load-use hazard unit over DEPTH post-EX stages.
// FWD_SCOREBOARD_STATS_EN adds saturating forward and stall counters.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned ADDR_W  = FWD_ADDR_W,
    parameter int unsigned LAT_W   = FWD_LAT_W,
    parameter int unsigned SEL_W   = $clog2(DEPTH + 1)
) (
    input logic            clk_i,
    input logic            rst_i,
    fwd_scoreboard_if.slave bus
);
    fwd_entry_t               trk [DEPTH];
    logic [NUM_SRC-1:0]       not_ready;
    logic [NUM_SRC*SEL_W-1:0] sel_bus;
    logic                     stall;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_op
        fwd_match #(
            .DEPTH (DEPTH),
            .ADDR_W(ADDR_W),
            .SEL_W (SEL_W)
        ) u_match (
            .trk      (trk),
            .src      (bus.src_addr_i[j*ADDR_W +: ADDR_W]),
            .sel      (sel_bus[j*SEL_W +: SEL_W]),
            .not_ready(not_ready[j])
        );
    end

    assign stall         = bus.iss_valid_i & (|not_ready);
    assign bus.stall_o   = stall;
    assign bus.src_sel_o = sel_bus;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < DEPTH; k++)
                trk[k] <= '0;
        end else if (!bus.hold_i) begin
            for (int unsigned k = 1; k < DEPTH; k++)
                trk[k] <= trk[k-1];
            trk[0].valid <= bus.iss_valid_i & bus.iss_wen_i & (bus.iss_rd_i != '0)
                            & ~bus.flush_i & ~stall;
            trk[0].rd    <= bus.iss_rd_i;
            trk[0].lat   <= bus.iss_lat_i;
        end
    end

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] fwd_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else if (!bus.hold_i) begin
            if (bus.iss_valid_i && (sel_bus != '0) && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + 32'd1;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.fwd_cnt_o   = fwd_cnt;
    assign bus.stall_cnt_o = stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random
// traffic against a history-queue model (stats checked with FWD_SCOREBOARD_STATS_EN).
module tb_fwd_scoreboard;
    localparam int unsigned NUM_SRC = 2;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned LAT_W   = 2;
    localparam int unsigned SEL_W   = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) bus ();

    fwd_scoreboard #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .SEL_W(SEL_W)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    typedef struct {
        bit v;
        int rd;
        int lat;
    } ent_t;

    ent_t hist[$];            // hist[0] is the instruction in stage 1
    int   vectors    = 0;
    int   miscompares = 0;

    int   cur_hold, cur_flush, cur_v, cur_wen, cur_rd, cur_lat;
    int   cur_src [NUM_SRC];
    int   exp_sel [NUM_SRC];
    int   exp_stall;
    longint m_fwd_cnt, m_stall_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dsel(input int j);
        logic [SEL_W-1:0] s;
        s = bus.src_sel_o[j*SEL_W +: SEL_W];
        return int'(s);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('{v: 0, rd: 0, lat: 0});
        m_fwd_cnt   = 0;
        m_stall_cnt = 0;
    endtask

    // Youngest in-flight writer of the source decides; its result is usable
    // once the instruction has reached the stage named by its latency tag.
    task automatic model_eval();
        bit any_nr;
        any_nr = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            exp_sel[j] = 0;
            if (cur_src[j] != 0) begin
                for (int k = 0; k < hist.size(); k++) begin
                    if (hist[k].v && hist[k].rd == cur_src[j]) begin
                        if ((hist[k].lat == 0 ? 1 : hist[k].lat) <= k + 1)
                            exp_sel[j] = k + 1;
                        else
                            any_nr = 1;
                        break;
                    end
                end
            end
        end
        exp_stall = (cur_v != 0 && any_nr) ? 1 : 0;
    endtask

    task automatic apply(input int hold, flush, v, wen, rd, lat, s0, s1);
        @(negedge clk);
        cur_hold = hold; cur_flush = flush; cur_v = v; cur_wen = wen;
        cur_rd = rd; cur_lat = lat; cur_src[0] = s0; cur_src[1] = s1;
        bus.hold_i      = hold[0];
        bus.flush_i     = flush[0];
        bus.iss_valid_i = v[0];
        bus.iss_wen_i   = wen[0];
        bus.iss_rd_i    = ADDR_W'(rd);
        bus.iss_lat_i   = LAT_W'(lat);
        bus.src_addr_i  = {ADDR_W'(s1), ADDR_W'(s0)};
        #1;
        model_eval();
        chk("sel0", dsel(0), exp_sel[0]);
        chk("sel1", dsel(1), exp_sel[1]);
        chk("stall", int'(bus.stall_o), exp_stall);
`ifdef FWD_SCOREBOARD_STATS_EN
        chk("fwd_cnt", longint'(bus.fwd_cnt_o), m_fwd_cnt);
        chk("stall_cnt", longint'(bus.stall_cnt_o), m_stall_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (cur_hold == 0) begin
            if (cur_v != 0 && (exp_sel[0] != 0 || exp_sel[1] != 0)) m_fwd_cnt++;
            if (exp_stall != 0) m_stall_cnt++;
            hist.push_front('{v: (cur_v != 0 && cur_wen != 0 && cur_rd != 0 &&
                                  cur_flush == 0 && exp_stall == 0),
                              rd: cur_rd, lat: cur_lat});
            void'(hist.pop_back());
        end
    endtask

    task automatic async_reset_check(input string name);
        #1 rst = 1'b1;
        #1;
        chk({name, "_sel0"}, dsel(0), 0);
        chk({name, "_stall"}, int'(bus.stall_o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.hold_i = 0; bus.flush_i = 0; bus.iss_valid_i = 0; bus.iss_wen_i = 0;
        bus.iss_rd_i = '0; bus.iss_lat_i = '0; bus.src_addr_i = '0;
        model_reset();
        #3;
        chk("reset_sel0", dsel(0), 0);
        chk("reset_stall", int'(bus.stall_o), 0);
        #5 rst = 1'b0;

        // ALU result walks down the pipe
        apply(0, 0, 1, 1, 3, 1, 0, 0); step();
        apply(0, 0, 1, 0, 0, 1, 3, 0); chk("alu_stage1", dsel(0), 1); step();
        apply(0, 0, 1, 0, 0, 1, 3, 0); chk("alu_stage2", dsel(0), 2); step();
        apply(0, 0, 1, 0, 0, 1, 3, 0); chk("alu_stage3", dsel(0), 3); step();
        apply(0, 0, 1, 0, 0, 1, 3, 0); chk("alu_retired", dsel(0), 0); step();

        // load-use: one stall, bubble, then bypass from stage 2
        apply(0, 0, 1, 1, 8, 2, 0, 0); step();
        apply(0, 0, 1, 1, 9, 1, 0, 8);
        chk("lu_stall", int'(bus.stall_o), 1);
        chk("lu_sel_nr", dsel(1), 0);
        step();
        apply(0, 0, 1, 0, 0, 1, 9, 8);
        chk("lu_unstall", int'(bus.stall_o), 0);
        chk("lu_sel2", dsel(1), 2);
        chk("lu_bubble", dsel(0), 0);
        step();

        // youngest producer shadows the older one
        apply(0, 0, 1, 1, 5, 1, 0, 0); step();
        apply(0, 0, 1, 1, 5, 1, 0, 0); step();
        apply(0, 0, 1, 0, 0, 1, 5, 5);
        chk("young_sel0", dsel(0), 1);
        chk("young_sel1", dsel(1), 1);
        step();

        // register zero is never tracked
        apply(0, 0, 1, 1, 0, 1, 0, 0); step();
        apply(0, 0, 1, 0, 0, 1, 0, 0);
        chk("r0_sel", dsel(0), 0);
        chk("r0_stall", int'(bus.stall_o), 0);
        step();

        // hold freezes, flush squashes the issuing slot
        apply(0, 0, 1, 1, 6, 1, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            apply(1, 1, 1, 1, 4, 2, 6, 0); chk("hold_sel", dsel(0), 1); step();
        end
        apply(0, 1, 1, 1, 4, 1, 6, 0); chk("flush_pre", dsel(0), 1); step();
        apply(0, 0, 1, 0, 0, 1, 4, 6);
        chk("flush_sel", dsel(0), 0);
        chk("flush_old", dsel(1), 2);
        step();

        // asynchronous reset with live entries and mid-stall
        apply(0, 0, 1, 1, 7, 1, 0, 0); step();
        apply(0, 0, 1, 0, 0, 1, 7, 0); chk("live_sel", dsel(0), 1);
        async_reset_check("rst_live");
        apply(0, 0, 1, 1, 10, 2, 0, 0); step();
        apply(0, 0, 1, 0, 0, 1, 10, 0); chk("pre_rst_stall", int'(bus.stall_o), 1);
        async_reset_check("rst_stall");

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(9) == 0) ? 1 : 0,
                  ($urandom_range(9) == 0) ? 1 : 0,
                  ($urandom_range(4) != 0) ? 1 : 0,
                  ($urandom_range(3) != 0) ? 1 : 0,
                  int'($urandom_range(7)),
                  int'($urandom_range(3)),
                  int'($urandom_range(7)),
                  int'($urandom_range(7)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
